defuzz_sequencer: RTL and testbench

//  Sequential centroid defuzzifier for the FLC output stage. Accepts one set of five

---
 rtl/defuzz_sequencer.sv | 158 +++++++++++++++
 tb/tb_defuzz_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/defuzz_sequencer.sv
// rtl/defuzz_sequencer.sv - sequential centroid defuzzifier (shared MAC, restoring divider)
module defuzz_sequencer #(
    parameter int W       = 8,
    parameter int C_NL    = 0,
    parameter int C_NS    = 64,
    parameter int C_Z     = 128,
    parameter int C_PS    = 192,
    parameter int C_PL    = 255,
    parameter int DEFAULT = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] fuzzy_nl,
    input  logic [W-1:0] fuzzy_ns,
    input  logic [W-1:0] fuzzy_z,
    input  logic [W-1:0] fuzzy_ps,
    input  logic [W-1:0] fuzzy_pl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] crisp_data,
    output logic         zero_div,
    output logic         busy
);
    localparam int ACC_W = 2*W + 3;
    localparam int SUM_W = W + 3;
    localparam int CNT_W = $clog2(ACC_W);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DIV, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       g_q [5];
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [SUM_W-1:0]   rem_q, rem_d;
    logic [2:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   bit_q, bit_d;
    logic [W-1:0]       crisp_q, crisp_d;
    logic               zdiv_q, zdiv_d;

    logic [W-1:0]       g_sel, c_sel;
    logic [2*W-1:0]     prod;
    logic [ACC_W-1:0]   acc_mac, acc_div;
    logic [SUM_W-1:0]   sum_mac, rem_div;
    logic [SUM_W:0]     rem_sh, rem_sub;
    logic               q_bit;

    // One multiplier and one subtractor, shared across all five sets / all quotient bits.
    always_comb begin
        g_sel = '0;
        c_sel = '0;
        case (idx_q)
            3'd0: begin g_sel = g_q[0]; c_sel = W'(C_NL); end
            3'd1: begin g_sel = g_q[1]; c_sel = W'(C_NS); end
            3'd2: begin g_sel = g_q[2]; c_sel = W'(C_Z);  end
            3'd3: begin g_sel = g_q[3]; c_sel = W'(C_PS); end
            3'd4: begin g_sel = g_q[4]; c_sel = W'(C_PL); end
            default: ;
        endcase
        prod    = {{W{1'b0}}, g_sel} * {{W{1'b0}}, c_sel};
        acc_mac = acc_q + {3'b000, prod};
        sum_mac = sum_q + {3'b000, g_sel};
        rem_sh  = {rem_q, acc_q[ACC_W-1]};
        rem_sub = rem_sh - {1'b0, sum_q};
        q_bit   = (rem_sh >= {1'b0, sum_q});
        rem_div = q_bit ? rem_sub[SUM_W-1:0] : rem_sh[SUM_W-1:0];
        // Dividend bits shift out the top while quotient bits shift in at the bottom.
        acc_div = {acc_q[ACC_W-2:0], q_bit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int i = 0; i < 5; i++) g_q[i] <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            bit_q   <= '0;
            crisp_q <= '0;
            zdiv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && in_valid) begin
                g_q[0] <= fuzzy_nl;
                g_q[1] <= fuzzy_ns;
                g_q[2] <= fuzzy_z;
                g_q[3] <= fuzzy_ps;
                g_q[4] <= fuzzy_pl;
            end
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            crisp_q <= crisp_d;
            zdiv_q  <= zdiv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = S_MAC;
            S_MAC:  if (idx_q == 3'd4) state_d = (sum_mac == '0) ? S_DONE : S_DIV;
            S_DIV:  if (bit_q == CNT_W'(ACC_W-1)) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_d   = acc_q;
        sum_d   = sum_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        crisp_d = crisp_q;
        zdiv_d  = zdiv_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                acc_d = '0;
                sum_d = '0;
                idx_d = '0;
            end
            S_MAC: begin
                acc_d = acc_mac;
                sum_d = sum_mac;
                idx_d = idx_q + 3'd1;
                rem_d = '0;
                bit_d = '0;
                if (idx_q == 3'd4 && sum_mac == '0) begin
                    crisp_d = W'(DEFAULT);
                    zdiv_d  = 1'b1;
                end
            end
            S_DIV: begin
                acc_d = acc_div;
                rem_d = rem_div;
                bit_d = bit_q + CNT_W'(1);
                if (bit_q == CNT_W'(ACC_W-1)) begin
                    crisp_d = acc_div[W-1:0];
                    zdiv_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == S_IDLE);
        out_valid  = (state_q == S_DONE);
        busy       = (state_q == S_MAC) || (state_q == S_DIV);
        crisp_data = crisp_q;
        zero_div   = zdiv_q;
    end
endmodule

// File: tb/tb_defuzz_sequencer.sv
// tb/tb_defuzz_sequencer.sv - scoreboard bench for defuzz_sequencer against a centroid model
module tb_defuzz_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] fuzzy_nl = '0, fuzzy_ns = '0, fuzzy_z = '0, fuzzy_ps = '0, fuzzy_pl = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] crisp_data;
    logic       zero_div;
    logic       busy;

    defuzz_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .fuzzy_nl(fuzzy_nl), .fuzzy_ns(fuzzy_ns), .fuzzy_z(fuzzy_z),
        .fuzzy_ps(fuzzy_ps), .fuzzy_pl(fuzzy_pl),
        .out_valid(out_valid), .out_ready(out_ready),
        .crisp_data(crisp_data), .zero_div(zero_div), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int crisp;
        int zd;
        int lat;
        int acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   cen [5] = '{0, 64, 128, 192, 255};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard when the consumer takes a result.
    logic       ov_prev = 1'b0;
    logic [7:0] crisp_prev = '0;
    logic       zd_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !ov_prev) begin
                if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
                else chk("latency", cyc - sb[0].acc_cyc, sb[0].lat);
            end
            if (out_valid && ov_prev) begin
                chk("crisp_stable", crisp_data, crisp_prev);
                chk("zero_div_stable", zero_div, zd_prev);
            end
            if (out_valid) chk("in_ready_in_done", in_ready, 0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_result", 1, 0);
                else begin
                    chk("crisp", crisp_data, sb[0].crisp);
                    chk("zero_div", zero_div, sb[0].zd);
                    void'(sb.pop_front());
                end
            end
        end
        ov_prev    <= out_valid;
        crisp_prev <= crisp_data;
        zd_prev    <= zero_div;
    end

    // Reference: weighted mean of centroids with integer truncation.
    task automatic do_accept(input int g0, g1, g2, g3, g4);
        int g [5];
        int num, den;
        bit ok;
        exp_t e;
        g = '{g0, g1, g2, g3, g4};
        fuzzy_nl = 8'(g0); fuzzy_ns = 8'(g1); fuzzy_z = 8'(g2);
        fuzzy_ps = 8'(g3); fuzzy_pl = 8'(g4);
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        num = 0; den = 0;
        foreach (g[i]) begin
            num += g[i] * cen[i];
            den += g[i];
        end
        e.acc_cyc = cyc;
        if (den == 0) begin e.crisp = 128; e.zd = 1; e.lat = 5; end
        else begin e.crisp = num / den; e.zd = 0; e.lat = 24; end
        sb.push_back(e);
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic run_txn(input int g0, g1, g2, g3, g4, input int stall, input bit junk);
        bit seen;
        do_accept(g0, g1, g2, g3, g4);
        out_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        if (!seen) begin
            chk("out_valid_timeout", 0, 1);
            void'(sb.pop_front());
            return;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < stall; i++) begin
            if (junk) begin
                in_valid = 1'b1;
                fuzzy_nl = 8'($urandom); fuzzy_ns = 8'($urandom); fuzzy_z = 8'($urandom);
                fuzzy_ps = 8'($urandom); fuzzy_pl = 8'($urandom);
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_crisp"}, crisp_data, 0);
        chk({tag, "_zero_div"}, zero_div, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int g [5];
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_txn(0, 0, 0, 0, 255, 0, 0);
        run_txn(100, 0, 0, 0, 100, 1, 0);
        run_txn(10, 10, 10, 10, 10, 0, 0);
        run_txn(0, 0, 200, 0, 0, 0, 0);
        run_txn(0, 0, 0, 0, 0, 2, 0);
        run_txn(30, 90, 0, 0, 7, 10, 1);

        // Abort a transaction mid-division; it must leave no result behind.
        do_accept(200, 0, 17, 0, 90);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_txn(0, 50, 0, 50, 0, 0, 0);

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 7) == 0) g = '{0, 0, 0, 0, 0};
            else foreach (g[i]) g[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
            run_txn(g[0], g[1], g[2], g[3], g[4], int'($urandom_range(0, 3)), 1'($urandom));
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
